// File: rtl/act_pingpong_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : act_pingpong_buffer_pkg
//  Description : Shared types and helper functions for the activation
//                ping-pong buffer: bank state encoding and derivation of the
//                packing factor, lane-index width and frame-length width.
//  Revision    : 1.0 - initial release
// ============================================================================
package act_pingpong_buffer_pkg;

    // Life cycle of one bank: the writer fills it, the PE takes it over,
    // then the PE hands it back.
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_READY   = 2'd2,
        BANK_OWNED   = 2'd3
    } bank_state_t;

    // Number of activations packed into one RAM word.
    function automatic int calc_pack(input int act_w, input int dwidth);
        return dwidth / act_w;
    endfunction

    // Width of a frame-length value. It must hold DEPTH*PACK.
    function automatic int calc_len_w(input int awidth, input int pack);
        return awidth + $clog2(pack) + 1;
    endfunction

    // Width of the lane counter. It is never allowed to be zero bits.
    function automatic int calc_lane_w(input int pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

endpackage : act_pingpong_buffer_pkg
`default_nettype wire

// File: rtl/act_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module      : act_bank_ram
//  Description : Simple dual-port RAM holding both ping-pong banks.
//                It has one synchronous write port and one registered read
//                port. A read and a write to the same address in the same
//                cycle return the old contents.
//  Ports       : clk      - clock
//                i_we     - write enable
//                i_waddr  - write address {bank, word}
//                i_wdata  - write data
//                i_re     - read enable
//                i_raddr  - read address {bank, word}
//                o_rdata  - read data, valid one cycle after i_re
//  Revision    : 1.0 - initial release
// ============================================================================
module act_bank_ram
    import act_pingpong_buffer_pkg::*;
#(
    parameter int AWIDTH = 14,
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AWIDTH-1:0] i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    localparam int WORDS = 2 ** AWIDTH;

    logic [DWIDTH-1:0] r_mem [WORDS];
    logic [DWIDTH-1:0] r_rdata;

    // The RAM has no reset, so that it maps onto block RAM. The read register
    // samples the array before this cycle's write lands.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : act_bank_ram
`default_nettype wire

// File: rtl/act_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : act_pingpong_buffer
//  Description : Packs an activation stream into RAM words and writes them
//                into two ping-pong banks. Each completed bank is offered to
//                the PE with a vld/ack handshake. The PE returns banks in
//                order with a release pulse.
//  Ports       : ap_clk, ap_rst_n    - clock, asynchronous active-low reset
//                cfg_frame_len       - activations per frame (latched on a
//                                      frame's first beat, 0 or too large
//                                      clamps to DEPTH*PACK)
//                act_tdata/tvalid/tready - activation stream
//                sync_bank/sync_vld/sync_ack - bank hand-over handshake
//                rel                 - PE releases its oldest owned bank
//                rd_bank/rd_addr/rd_ce/rd_q - PE read port (1-cycle latency)
//                bank_busy           - per-bank "not EMPTY" flags
//                err                 - sticky protocol error
//  Revision    : 1.0 - initial release
// ============================================================================
module act_pingpong_buffer
    import act_pingpong_buffer_pkg::*;
#(
    parameter int ACT_W  = 8,
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 13,
    parameter int LEN_W  = calc_len_w(AWIDTH, calc_pack(ACT_W, DWIDTH))
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [LEN_W-1:0]  cfg_frame_len,
    input  logic [ACT_W-1:0]  act_tdata,
    input  logic              act_tvalid,
    output logic              act_tready,
    output logic              sync_bank,
    output logic              sync_vld,
    input  logic              sync_ack,
    input  logic              rel,
    input  logic              rd_bank,
    input  logic [AWIDTH-1:0] rd_addr,
    input  logic              rd_ce,
    output logic [DWIDTH-1:0] rd_q,
    output logic [1:0]        bank_busy,
    output logic              err
);

    localparam int PACK   = calc_pack(ACT_W, DWIDTH);
    localparam int LANE_W = calc_lane_w(PACK);
    localparam int DEPTH  = 2 ** AWIDTH;

    localparam logic [LEN_W-1:0]  c_MAX_LEN   = LEN_W'(DEPTH * PACK);
    localparam logic [LANE_W-1:0] c_LAST_LANE = LANE_W'(PACK - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    bank_state_t       r_state [2];
    logic              r_wr_bank;
    logic              r_hand_bank;
    logic              r_rel_bank;
    logic [LANE_W-1:0] r_lane;
    logic [AWIDTH-1:0] r_wr_addr;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic [LEN_W-1:0]  r_frame_len;
    logic [DWIDTH-1:0] r_pack;
    logic              r_tready;
    logic              r_err;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic              w_accept;
    logic              w_first;
    logic [LEN_W-1:0]  w_cfg_len;
    logic [LEN_W-1:0]  w_len;
    logic [LEN_W-1:0]  w_beat_inc;
    logic              w_last;
    logic              w_complete;
    logic              w_we;
    logic [DWIDTH-1:0] w_word;

    assign w_accept   = act_tvalid & r_tready;
    assign w_first    = (r_beat_cnt == '0);
    assign w_cfg_len  = ((cfg_frame_len == '0) || (cfg_frame_len > c_MAX_LEN))
                        ? c_MAX_LEN : cfg_frame_len;
    // The first beat closes the frame on the freshly sampled length, so a
    // one-beat frame completes on its only beat.
    assign w_len      = w_first ? w_cfg_len : r_frame_len;
    assign w_beat_inc = r_beat_cnt + 1'b1;
    assign w_last     = (w_beat_inc == w_len);
    assign w_complete = (r_lane == c_LAST_LANE) || w_last;
    assign w_we       = w_accept & w_complete;

    // r_pack holds the lanes already received for this word. Its upper lanes
    // are always zero, so a short final word pads with zeros.
    always_comb begin
        w_word = r_pack;
        for (int l = 0; l < PACK; l++) begin
            if (r_lane == LANE_W'(l)) begin
                w_word[l*ACT_W +: ACT_W] = act_tdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Hand-over and release
    // ------------------------------------------------------------------
    logic w_sync_vld;
    logic w_xfer;
    logic w_rel_ok;

    assign w_sync_vld = (r_state[r_hand_bank] == BANK_READY);
    assign w_xfer     = w_sync_vld & sync_ack;
    // Banks are handed over and released in the same alternating order.
    // r_rel_bank therefore always points at the oldest owned bank, if any.
    assign w_rel_ok   = rel & (r_state[r_rel_bank] == BANK_OWNED);

    // ------------------------------------------------------------------
    // Next bank states. Each event needs a bank in a different state, so at
    // most one event can touch any given bank in a cycle.
    // ------------------------------------------------------------------
    bank_state_t w_state_nxt [2];
    logic        w_wr_bank_nxt;
    logic        w_tready_nxt;

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_nxt[b] = r_state[b];
            if (w_accept && (r_wr_bank == 1'(b))) begin
                w_state_nxt[b] = w_last ? BANK_READY : BANK_FILLING;
            end
            if (w_xfer && (r_hand_bank == 1'(b))) begin
                w_state_nxt[b] = BANK_OWNED;
            end
            if (w_rel_ok && (r_rel_bank == 1'(b))) begin
                w_state_nxt[b] = BANK_EMPTY;
            end
        end
    end

    assign w_wr_bank_nxt = r_wr_bank ^ (w_accept & w_last);
    // tready is registered from the next state. This lets it drop in the same
    // cycle the writer moves onto a bank that is still occupied.
    assign w_tready_nxt  = (w_state_nxt[w_wr_bank_nxt] == BANK_EMPTY) ||
                           (w_state_nxt[w_wr_bank_nxt] == BANK_FILLING);

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state[0]  <= BANK_EMPTY;
            r_state[1]  <= BANK_EMPTY;
            r_wr_bank   <= 1'b0;
            r_hand_bank <= 1'b0;
            r_rel_bank  <= 1'b0;
            r_lane      <= '0;
            r_wr_addr   <= '0;
            r_beat_cnt  <= '0;
            r_frame_len <= '0;
            r_pack      <= '0;
            r_tready    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
            r_wr_bank  <= w_wr_bank_nxt;
            r_tready   <= w_tready_nxt;

            if (w_xfer) begin
                r_hand_bank <= ~r_hand_bank;
            end
            if (w_rel_ok) begin
                r_rel_bank <= ~r_rel_bank;
            end
            if ((rel && !w_rel_ok) || (sync_ack && !w_sync_vld)) begin
                r_err <= 1'b1;
            end

            if (w_accept) begin
                if (w_first) begin
                    r_frame_len <= w_cfg_len;
                end
                if (w_last) begin
                    r_lane     <= '0;
                    r_wr_addr  <= '0;
                    r_beat_cnt <= '0;
                    r_pack     <= '0;
                end else if (w_complete) begin
                    r_lane     <= '0;
                    r_wr_addr  <= r_wr_addr + 1'b1;
                    r_beat_cnt <= w_beat_inc;
                    r_pack     <= '0;
                end else begin
                    r_lane     <= r_lane + 1'b1;
                    r_beat_cnt <= w_beat_inc;
                    r_pack     <= w_word;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank storage
    // ------------------------------------------------------------------
    act_bank_ram #(
        .AWIDTH (AWIDTH + 1),
        .DWIDTH (DWIDTH)
    ) u_ram (
        .clk     (ap_clk),
        .i_we    (w_we),
        .i_waddr ({r_wr_bank, r_wr_addr}),
        .i_wdata (w_word),
        .i_re    (rd_ce),
        .i_raddr ({rd_bank, rd_addr}),
        .o_rdata (rd_q)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign act_tready = r_tready;
    assign sync_vld   = w_sync_vld;
    assign sync_bank  = r_hand_bank;
    assign bank_busy  = {(r_state[1] != BANK_EMPTY), (r_state[0] != BANK_EMPTY)};
    assign err        = r_err;

endmodule : act_pingpong_buffer
`default_nettype wire
